// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) memory arbiter with alternating tie-break, byte-lane formatting and
// an optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_r,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_byte,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_r,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant,
    output logic        err
);

    // state | meaning
    // IDLE  | no owner; arbitrate and latch the winner's request
    // ACC   | mem_en asserted from latched request, waiting for mem_ready (or timeout)
    // DONE  | owner's completion pulse, grant still held
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state, state_nxt;
    logic        owner, owner_nxt;            // 0 = CPU, 1 = DMA
    logic        last_owner, last_owner_nxt;
    logic        latch, complete, timeout_hit;
    logic [15:0] l_addr, l_wdata;
    logic        l_we, l_byte;
    logic [7:0]  rd_lane;
    logic [15:0] rd_val;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        latch          = 1'b0;
        complete       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_nxt = ACC;
                    latch     = 1'b1;
                    owner_nxt = (cpu_req && dma_req) ? ~last_owner : dma_req;
                end
            end
            ACC: begin
                if (mem_ready || timeout_hit) begin
                    complete       = 1'b1;
                    state_nxt      = DONE;
                    last_owner_nxt = owner;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_we       <= 1'b0;
            l_byte     <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            if (latch) begin
                l_addr  <= owner_nxt ? dma_addr  : cpu_addr;
                l_wdata <= owner_nxt ? dma_wdata : cpu_wdata;
                l_we    <= owner_nxt ? dma_we    : cpu_we;
                l_byte  <= owner_nxt ? dma_byte  : cpu_byte;
            end
        end
    end

    // A timed-out read returns zero; mem_ready has priority if both coincide.
    assign rd_lane = l_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign rd_val  = !mem_ready ? 16'h0000 :
                     l_byte     ? {{8{rd_lane[7]}}, rd_lane} : mem_rdata;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (complete && !l_we) begin
            if (owner) dma_rdata <= rd_val;
            else       cpu_rdata <= rd_val;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] acc_cnt;

    assign timeout_hit = (state == ACC) && !mem_ready && (acc_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (latch)              acc_cnt <= '0;
            else if (state == ACC)  acc_cnt <= acc_cnt + 8'd1;
            if (timeout_hit)        err     <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign mem_en    = (state == ACC);
    assign mem_we    = mem_en & l_we;
    assign mem_be    = !mem_en ? 2'b00 :
                       !l_byte ? 2'b11 :
                       l_addr[0] ? 2'b10 : 2'b01;
    assign mem_addr  = mem_en ? {l_addr[15:1], 1'b0} : 16'h0000;
    assign mem_wdata = !mem_en ? 16'h0000 :
                       l_byte  ? {l_wdata[7:0], l_wdata[7:0]} : l_wdata;
    assign grant     = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign cpu_r     = (state == DONE) && !owner;
    assign dma_r     = (state == DONE) &&  owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the timeout scenario follows MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_r;
    logic        dma_req, dma_we, dma_byte;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_r;
    logic        mem_en, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [1:0]  grant;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cpu, exp_dma;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
        .dma_req(dma_req), .dma_we(dma_we), .dma_byte(dma_byte), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_r(dma_r),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .err(err)
    );

    always #10 clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #5;
        n_vec++; if (grant !== 2'b00)      begin n_err++; $display("FAIL rst_grant: got %b want 00", grant); end
        n_vec++; if (mem_en !== 1'b0)      begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        n_vec++; if (cpu_rdata !== 16'h0)  begin n_err++; $display("FAIL rst_cpu_rdata: got %h want 0000", cpu_rdata); end
        n_vec++; if (dma_rdata !== 16'h0)  begin n_err++; $display("FAIL rst_dma_rdata: got %h want 0000", dma_rdata); end
        n_vec++; if ({cpu_r, dma_r, err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {cpu_r, dma_r, err}); end
        n_vec++; if (mem_addr !== 16'h0 || mem_be !== 2'b00) begin n_err++; $display("FAIL rst_mem_bus: got %h/%b want 0000/00", mem_addr, mem_be); end
        tick(); tick();
        reset_n = 1'b1;
        exp_cpu = 16'h0000;
        exp_dma = 16'h0000;
        tick();
    endtask

    task automatic test_word_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h3001;
        tick();
        cpu_req = 1'b0;
        n_vec++; if (mem_en !== 1'b1)        begin n_err++; $display("FAIL wr_mem_en: got %b want 1", mem_en); end
        n_vec++; if (mem_addr !== 16'h3000)  begin n_err++; $display("FAIL wr_mem_addr: got %h want 3000", mem_addr); end
        n_vec++; if (mem_be !== 2'b11)       begin n_err++; $display("FAIL wr_mem_be: got %b want 11", mem_be); end
        n_vec++; if (mem_we !== 1'b0)        begin n_err++; $display("FAIL wr_mem_we: got %b want 0", mem_we); end
        n_vec++; if (grant !== 2'b01)        begin n_err++; $display("FAIL wr_grant: got %b want 01", grant); end
        cpu_addr = 16'hFFFF;
        tick();
        n_vec++; if (mem_addr !== 16'h3000)  begin n_err++; $display("FAIL wr_addr_held: got %h want 3000", mem_addr); end
        tick();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        n_vec++; if (cpu_r !== 1'b0)         begin n_err++; $display("FAIL wr_r_early: got %b want 0", cpu_r); end
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'hBEEF;
        n_vec++; if (cpu_r !== 1'b1)         begin n_err++; $display("FAIL wr_cpu_r: got %b want 1", cpu_r); end
        n_vec++; if (cpu_rdata !== exp_cpu)  begin n_err++; $display("FAIL wr_cpu_rdata: got %h want %h", cpu_rdata, exp_cpu); end
        n_vec++; if (mem_en !== 1'b0 || mem_addr !== 16'h0) begin n_err++; $display("FAIL wr_done_bus: got %b/%h want 0/0000", mem_en, mem_addr); end
        n_vec++; if (grant !== 2'b01)        begin n_err++; $display("FAIL wr_done_grant: got %b want 01", grant); end
        tick();
        n_vec++; if (cpu_r !== 1'b0 || grant !== 2'b00) begin n_err++; $display("FAIL wr_idle: got r=%b grant=%b want 0/00", cpu_r, grant); end
        n_vec++; if (cpu_rdata !== exp_cpu)  begin n_err++; $display("FAIL wr_rdata_hold: got %h want %h", cpu_rdata, exp_cpu); end
    endtask

    task automatic test_alternation();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_cpu = 16'h0000; exp_dma = 16'h0000;
        tick();
        cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0; cpu_byte = 1'b0; dma_byte = 1'b0;
        cpu_addr = 16'h0100; dma_addr = 16'h0200;
        tick();
        n_vec++; if (grant !== 2'b01)  begin n_err++; $display("FAIL alt_first: got %b want 01", grant); end
        mem_ready = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'h1111;
        n_vec++; if (cpu_r !== 1'b1 || cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL alt_cpu_done: got r=%b %h want 1 %h", cpu_r, cpu_rdata, exp_cpu); end
        tick();
        n_vec++; if (grant !== 2'b00)  begin n_err++; $display("FAIL alt_idle: got %b want 00", grant); end
        tick();
        n_vec++; if (grant !== 2'b10)  begin n_err++; $display("FAIL alt_second: got %b want 10", grant); end
        n_vec++; if (mem_addr !== 16'h0200) begin n_err++; $display("FAIL alt_dma_addr: got %h want 0200", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 16'h2222;
        tick();
        mem_ready = 1'b0;
        exp_dma = 16'h2222;
        n_vec++; if (dma_r !== 1'b1 || cpu_r !== 1'b0) begin n_err++; $display("FAIL alt_dma_r: got dma_r=%b cpu_r=%b want 1/0", dma_r, cpu_r); end
        n_vec++; if (dma_rdata !== exp_dma || cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL alt_rdata: got %h/%h want %h/%h", dma_rdata, cpu_rdata, exp_dma, exp_cpu); end
        tick();
        tick();
        n_vec++; if (grant !== 2'b01)  begin n_err++; $display("FAIL alt_third: got %b want 01", grant); end
        cpu_req = 1'b0; dma_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h3333;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'h3333;
        n_vec++; if (cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL alt_third_rdata: got %h want %h", cpu_rdata, exp_cpu); end
        tick();
    endtask

    task automatic test_dma_byte_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_byte = 1'b1; dma_addr = 16'h0041; dma_wdata = 16'h12A5;
        tick();
        dma_req = 1'b0; dma_we = 1'b0; dma_byte = 1'b0;
        n_vec++; if (grant !== 2'b10)         begin n_err++; $display("FAIL dbw_grant: got %b want 10", grant); end
        n_vec++; if (mem_be !== 2'b10)        begin n_err++; $display("FAIL dbw_be: got %b want 10", mem_be); end
        n_vec++; if (mem_wdata !== 16'hA5A5)  begin n_err++; $display("FAIL dbw_wdata: got %h want a5a5", mem_wdata); end
        n_vec++; if (mem_we !== 1'b1)         begin n_err++; $display("FAIL dbw_we: got %b want 1", mem_we); end
        n_vec++; if (mem_addr !== 16'h0040)   begin n_err++; $display("FAIL dbw_addr: got %h want 0040", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ready = 1'b0;
        n_vec++; if (dma_r !== 1'b1)          begin n_err++; $display("FAIL dbw_r: got %b want 1", dma_r); end
        n_vec++; if (dma_rdata !== exp_dma)   begin n_err++; $display("FAIL dbw_rdata_kept: got %h want %h", dma_rdata, exp_dma); end
        n_vec++; if (mem_we !== 1'b0 || mem_wdata !== 16'h0) begin n_err++; $display("FAIL dbw_done_bus: got %b/%h want 0/0000", mem_we, mem_wdata); end
        tick();
    endtask

    task automatic test_byte_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b1; cpu_addr = 16'h0010;
        tick();
        cpu_req = 1'b0;
        n_vec++; if (mem_be !== 2'b01 || mem_addr !== 16'h0010) begin n_err++; $display("FAIL br_lo_bus: got %b/%h want 01/0010", mem_be, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 16'h0080;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'hFF80;
        n_vec++; if (cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL br_lo_sext: got %h want %h", cpu_rdata, exp_cpu); end
        tick();
        cpu_req = 1'b1; cpu_addr = 16'h0011;
        tick();
        cpu_req = 1'b0;
        n_vec++; if (mem_be !== 2'b10 || mem_addr !== 16'h0010) begin n_err++; $display("FAIL br_hi_bus: got %b/%h want 10/0010", mem_be, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 16'h7F00;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'h007F;
        n_vec++; if (cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL br_hi_sext: got %h want %h", cpu_rdata, exp_cpu); end
        tick();
        cpu_byte = 1'b0;
    endtask

    task automatic test_cpu_word_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0102; cpu_wdata = 16'h5AC3;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        n_vec++; if (mem_wdata !== 16'h5AC3 || mem_be !== 2'b11 || mem_we !== 1'b1) begin n_err++; $display("FAIL cww_bus: got %h/%b/%b want 5ac3/11/1", mem_wdata, mem_be, mem_we); end
        mem_ready = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ready = 1'b0;
        n_vec++; if (cpu_r !== 1'b1 || cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL cww_done: got r=%b %h want 1 %h", cpu_r, cpu_rdata, exp_cpu); end
        tick();
    endtask

    task automatic test_ready_outside_acc();
        mem_ready = 1'b1; mem_rdata = 16'hFFFF;
        tick(); tick(); tick();
        n_vec++; if (grant !== 2'b00 || mem_en !== 1'b0) begin n_err++; $display("FAIL roa_idle: got %b/%b want 00/0", grant, mem_en); end
        n_vec++; if ({cpu_r, dma_r} !== 2'b00) begin n_err++; $display("FAIL roa_r: got %b want 00", {cpu_r, dma_r}); end
        n_vec++; if (cpu_rdata !== exp_cpu || dma_rdata !== exp_dma) begin n_err++; $display("FAIL roa_rdata: got %h/%h want %h/%h", cpu_rdata, dma_rdata, exp_cpu, exp_dma); end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        // last completion was the CPU, so a tie goes to the DMA
        cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
        tick();
        n_vec++; if (grant !== 2'b10) begin n_err++; $display("FAIL rma_pre_grant: got %b want 10", grant); end
        #4;
        reset_n = 1'b0;
        #1;
        n_vec++; if (mem_en !== 1'b0 || grant !== 2'b00) begin n_err++; $display("FAIL rma_async: got %b/%b want 0/00", mem_en, grant); end
        tick();
        n_vec++; if ({cpu_r, dma_r} !== 2'b00) begin n_err++; $display("FAIL rma_no_r: got %b want 00", {cpu_r, dma_r}); end
        exp_cpu = 16'h0000; exp_dma = 16'h0000;
        n_vec++; if (cpu_rdata !== exp_cpu || dma_rdata !== exp_dma) begin n_err++; $display("FAIL rma_rdata: got %h/%h want 0000/0000", cpu_rdata, dma_rdata); end
        reset_n = 1'b1;
        tick();
        n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL rma_cpu_first: got %b want 01", grant); end
        cpu_req = 1'b0; dma_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h4321;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'h4321;
        n_vec++; if (cpu_r !== 1'b1 || cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL rma_after: got r=%b %h want 1 %h", cpu_r, cpu_rdata, exp_cpu); end
        tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0200;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL to_mem_en[%0d]: got %b want 1", i, mem_en); end
            tick();
        end
        n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL to_drop: got %b want 0", mem_en); end
        n_vec++; if (err !== 1'b1)    begin n_err++; $display("FAIL to_err: got %b want 1", err); end
        n_vec++; if (cpu_r !== 1'b1)  begin n_err++; $display("FAIL to_cpu_r: got %b want 1", cpu_r); end
        exp_cpu = 16'h0000;
        n_vec++; if (cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL to_rdata: got %h want 0000", cpu_rdata); end
        tick(); tick();
        n_vec++; if (err !== 1'b1 || grant !== 2'b00) begin n_err++; $display("FAIL to_sticky: got %b/%b want 1/00", err, grant); end
    endtask
`else
    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0200;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        n_vec++; if (mem_en !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL nto_wait: got mem_en=%b err=%b want 1/0", mem_en, err); end
        mem_ready = 1'b1; mem_rdata = 16'h0F0F;
        tick();
        mem_ready = 1'b0;
        exp_cpu = 16'h0F0F;
        n_vec++; if (cpu_r !== 1'b1 || cpu_rdata !== exp_cpu) begin n_err++; $display("FAIL nto_done: got r=%b %h want 1 %h", cpu_r, cpu_rdata, exp_cpu); end
        tick();
    endtask
`endif

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_byte = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        exp_cpu = '0; exp_dma = '0;
        test_reset();
        test_word_read();
        test_alternation();
        test_dma_byte_write();
        test_byte_read();
        test_cpu_word_write();
        test_ready_outside_acc();
        test_reset_mid_access();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
